i2c_config_sequencer: RTL and testbench



---
 rtl/i2c_config_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_i2c_config_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer: walks a small byte table and issues each byte to the I2C controller
// using one start/ready handshake per byte. Optional per-transfer timeout: I2C_SEQ_TIMEOUT_EN.
module i2c_config_sequencer #(
  parameter int         DEPTH          = 8,
  parameter int         IDX_W          = 3,
  parameter logic [6:0] DEV_ADDR       = 7'h48,
  parameter int         TIMEOUT_CYCLES = 200000
) (
  input  logic             ref_clk,
  input  logic             reset,
  input  logic             go,
  input  logic [IDX_W:0]   cfg_count,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic             i2c_ready,
  output logic             i2c_start,
  output logic [6:0]       i2c_addr,
  output logic [7:0]       i2c_data,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] word_idx
);

  // state | meaning
  // IDLE  | waiting for go; table is writable
  // LOAD  | put table[word_idx] on i2c_data
  // ISSUE | hold i2c_start until the controller drops ready
  // WAIT  | controller busy; wait for ready to come back
  // FIN   | done pulse, back to IDLE
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_FIN} state_t;

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

  if (DEPTH > 16 || (1 << IDX_W) != DEPTH || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("i2c_config_sequencer: bad DEPTH/IDX_W/TIMEOUT_CYCLES");
  end

  state_t           state_q, state_d;
  logic             rdy_meta_q, rdy_s_q;
  logic [7:0]       tbl_q [DEPTH];
  logic [7:0]       tbl_d [DEPTH];
  logic [IDX_W:0]   count_q, count_d, count_last;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             tmo_hit;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_hit = (state_q == S_ISSUE || state_q == S_WAIT) && (tmo_q == '0);

  // Down-counter armed in LOAD; terminal count ends the transfer.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == S_LOAD) begin
      tmo_d = TMO_LOAD;
    end else if ((state_q == S_ISSUE || state_q == S_WAIT) && tmo_q != '0) begin
      tmo_d = tmo_q - TMO_W'(1);
    end
  end

  always_ff @(posedge ref_clk) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign count_last = count_q - (IDX_W + 1)'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    data_d  = data_q;
    start_d = start_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    tbl_d   = tbl_q;

    if (wr_en && state_q == S_IDLE) tbl_d[wr_idx] = wr_data;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          error_d = 1'b0;
          idx_d   = '0;
          if (cfg_count == '0) begin
            done_d = 1'b1;
          end else begin
            count_d = (cfg_count > DEPTH_L) ? DEPTH_L : cfg_count;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        data_d  = tbl_q[idx_q];
        busy_d  = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // Only a low ready seen while start is already up counts as acceptance.
        if (start_q && !rdy_s_q) begin
          start_d = 1'b0;
          state_d = S_WAIT;
        end else begin
          start_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (rdy_s_q) begin
          if ({1'b0, idx_q} == count_last) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            idx_d   = '0;
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (tmo_hit) begin
      error_d = 1'b1;
      start_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      idx_d   = '0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rdy_meta_q <= 1'b1;
      rdy_s_q    <= 1'b1;
      tbl_q      <= '{default: '0};
      count_q    <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_meta_q <= i2c_ready;
      rdy_s_q    <= rdy_meta_q;
      tbl_q      <= tbl_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign i2c_start = start_q;
  assign i2c_addr  = DEV_ADDR;
  assign i2c_data  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign word_idx  = idx_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer: a behavioural I2C controller plus a table model; every
// sequence is checked for byte order, index, handshake timing, done/busy behaviour.
module tb_i2c_config_sequencer;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;
  localparam int TMO   = 100;

  logic             ref_clk = 1'b0;
  logic             reset, go, wr_en, i2c_ready;
  logic [IDX_W:0]   cfg_count;
  logic [IDX_W-1:0] wr_idx;
  logic [7:0]       wr_data;
  logic             i2c_start, busy, done, error;
  logic [6:0]       i2c_addr;
  logic [7:0]       i2c_data;
  logic [IDX_W-1:0] word_idx;

  always #5 ref_clk = ~ref_clk;

  i2c_config_sequencer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DEV_ADDR(7'h48), .TIMEOUT_CYCLES(TMO)) dut (
    .ref_clk(ref_clk), .reset(reset), .go(go), .cfg_count(cfg_count), .wr_en(wr_en),
    .wr_idx(wr_idx), .wr_data(wr_data), .i2c_ready(i2c_ready), .i2c_start(i2c_start),
    .i2c_addr(i2c_addr), .i2c_data(i2c_data), .busy(busy), .done(done), .error(error),
    .word_idx(word_idx)
  );

  int vecs = 0;
  int miss = 0;

  logic [7:0] tbl [DEPTH];
  logic [7:0] cap_data[$];
  int         cap_idx[$];
  int         accept_dly = 0;
  int         busy_len = 6;
  bit         ctl_stuck = 1'b0;
  bit         stab_en = 1'b1;
  int         start_gaps = 0;
  int         data_changes = 0;
  int         drop_lat = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slow I2C controller: accepts a held start after accept_dly cycles, then stays busy.
  initial begin
    i2c_ready = 1'b1;
    forever begin
      @(negedge ref_clk);
      if (i2c_start === 1'b1 && !ctl_stuck && reset !== 1'b1) begin
        for (int i = 0; i < accept_dly; i++) begin
          @(negedge ref_clk);
          if (i2c_start !== 1'b1) start_gaps++;
        end
        cap_data.push_back(i2c_data);
        cap_idx.push_back(int'(word_idx));
        i2c_ready = 1'b0;
        drop_lat = 0;
        for (int i = 0; i < busy_len; i++) begin
          @(negedge ref_clk);
          if (drop_lat == 0 && i2c_start === 1'b0) drop_lat = i + 1;
          if (stab_en && i2c_data !== cap_data[$]) data_changes++;
        end
        i2c_ready = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wr_tbl(input int idx, input logic [7:0] d);
    @(negedge ref_clk);
    wr_en = 1'b1; wr_idx = IDX_W'(idx); wr_data = d;
    @(negedge ref_clk);
    wr_en = 1'b0;
    tbl[idx] = d;
  endtask

  task automatic start_seq(input int cnt, input bit w, input logic [7:0] wd);
    int k;
    cap_data.delete(); cap_idx.delete();
    start_gaps = 0; data_changes = 0; drop_lat = 0;
    @(negedge ref_clk);
    go = 1'b1; cfg_count = (IDX_W + 1)'(cnt);
    if (w) begin
      wr_en = 1'b1; wr_idx = '0; wr_data = wd; tbl[0] = wd;
    end
    @(negedge ref_clk);
    go = 1'b0; wr_en = 1'b0;
    k = 1;
    while (i2c_start !== 1'b1 && k < 10) begin
      @(negedge ref_clk);
      k++;
    end
    chk("start_latency", k, 3);
  endtask

  task automatic finish_seq(input int n);
    int   dones = 0;
    bit   seen = 1'b0;
    logic prev_busy;
    prev_busy = busy;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge ref_clk);
      if (done === 1'b1) begin
        seen = 1'b1; dones++;
        chk("busy_at_done", busy, 0);
        chk("busy_before_done", prev_busy, 1);
        chk("idx_at_done", word_idx, 0);
      end
      prev_busy = busy;
    end
    chk("done_seen", seen, 1);
    repeat (5) begin
      @(negedge ref_clk);
      if (done === 1'b1) dones++;
    end
    chk("done_count", dones, 1);
    chk("byte_count", cap_data.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < cap_data.size()) begin
        chk($sformatf("byte%0d", i), cap_data[i], tbl[i]);
        chk($sformatf("idx%0d", i), cap_idx[i], i);
      end
    end
    chk("start_held", start_gaps, 0);
    chk("data_stable", data_changes, 0);
    chk("start_drop_lat", drop_lat, 3);
    chk("error_low", error, 0);
  endtask

  task automatic zero_go();
    bit started = 1'b0;
    cap_data.delete();
    @(negedge ref_clk);
    go = 1'b1; cfg_count = '0;
    @(negedge ref_clk);
    go = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(negedge ref_clk);
    chk("zero_done_once", done, 0);
    repeat (6) begin
      if (i2c_start !== 1'b0 || busy !== 1'b0) started = 1'b1;
      @(negedge ref_clk);
    end
    chk("zero_no_start", started, 0);
  endtask

  task automatic run(input int cnt);
    int n;
    n = (cnt > DEPTH) ? DEPTH : cnt;
    if (n == 0) zero_go();
    else begin
      start_seq(cnt, 1'b0, 8'h00);
      finish_seq(n);
    end
  endtask

  initial begin
    int  k;
    bit  bad;
    reset = 1'b1; go = 1'b0; cfg_count = '0; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    for (int i = 0; i < DEPTH; i++) tbl[i] = 8'h00;
    repeat (3) @(negedge ref_clk);
    chk("rst_start", i2c_start, 0);
    chk("rst_data", i2c_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_idx", word_idx, 0);
    chk("addr", i2c_addr, 7'h48);
    reset = 1'b0;
    @(negedge ref_clk);

    busy_len = 4;
    run(2);

    wr_tbl(0, 8'hA1); wr_tbl(1, 8'hB2); wr_tbl(2, 8'hC3);
    busy_len = 40;
    run(3);

    busy_len = 6;
    run(0);

    accept_dly = 10;
    run(1);
    accept_dly = 0;

    busy_len = 20;
    start_seq(3, 1'b0, 8'h00);
    repeat (5) begin
      wr_en = 1'b1; wr_idx = 3'd1; wr_data = 8'hFF;
      @(negedge ref_clk);
    end
    wr_en = 1'b0;
    finish_seq(3);
    run(3);

    busy_len = 5;
    start_seq(2, 1'b1, 8'h5A);
    finish_seq(2);

    for (int i = 0; i < DEPTH; i++) wr_tbl(i, 8'($urandom));
    run(15);
    run(9);
    run(8);

    for (int it = 0; it < 12; it++) begin
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) wr_tbl($urandom_range(0, DEPTH - 1), 8'($urandom));
      busy_len   = $urandom_range(4, 12);
      accept_dly = $urandom_range(0, 3);
      run($urandom_range(0, 15));
    end
    accept_dly = 0;

    for (int i = 0; i < 4; i++) wr_tbl(i, 8'($urandom_range(1, 255)));
    busy_len = 30;
    stab_en = 1'b0;
    start_seq(4, 1'b0, 8'h00);
    k = 0;
    while (cap_data.size() < 2 && k < 500) begin
      @(negedge ref_clk);
      k++;
    end
    chk("rst_mid_reached", cap_data.size(), 2);
    repeat (5) @(negedge ref_clk);
    reset = 1'b1;
    @(negedge ref_clk);
    chk("mid_rst_start", i2c_start, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_idx", word_idx, 0);
    chk("mid_rst_data", i2c_data, 0);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) tbl[i] = 8'h00;
    bad = 1'b0;
    repeat (40) begin
      @(negedge ref_clk);
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("mid_rst_quiet", bad, 0);
    k = 0;
    while (i2c_ready !== 1'b1 && k < 200) begin
      @(negedge ref_clk);
      k++;
    end
    repeat (3) @(negedge ref_clk);
    stab_en = 1'b1;
    busy_len = 6;
    wr_tbl(1, 8'h3C);
    run(2);

`ifdef I2C_SEQ_TIMEOUT_EN
    ctl_stuck = 1'b1;
    start_seq(2, 1'b0, 8'h00);
    k = 1;
    bad = 1'b0;
    for (int c = 0; c < 1000 && error !== 1'b1; c++) begin
      @(negedge ref_clk);
      if (done === 1'b1) bad = 1'b1;
      if (error !== 1'b1 && i2c_start === 1'b1) k++;
    end
    chk("tmo_error", error, 1);
    chk("tmo_start_cycles", k, TMO - 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_start", i2c_start, 0);
    chk("tmo_idx", word_idx, 0);
    chk("tmo_no_done", bad, 0);
    ctl_stuck = 1'b0;
    @(negedge ref_clk);
    chk("tmo_sticky", error, 1);
    go = 1'b1; cfg_count = '0;
    @(negedge ref_clk);
    go = 1'b0;
    chk("tmo_clear", error, 0);
    chk("tmo_clear_done", done, 1);
`else
    chk("error_tied", error, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
